// File: rtl/state_pkg.sv
// state_pkg: screen encoding shared by the game sequencer and the screen-select mux
package state_pkg;
  typedef enum logic [1:0] {
    START   = 2'd0,
    LEVEL_1 = 2'd1,
    FINISH  = 2'd2
  } g_state;
endpackage

// File: rtl/game_state_ctl_if.sv
// game_state_ctl_if: mouse/player/frame inputs and screen outputs of the game sequencer
// master drives mouse_*, xpos_*/ypos_*, vblnk and reads game_state/level_init; slave is the sequencer side
interface game_state_ctl_if;
  logic                 mouse_left;
  logic                 mouse_right;
  logic [11:0]          xpos_mouse;
  logic [11:0]          ypos_mouse;
  logic [11:0]          xpos_player1;
  logic [11:0]          ypos_player1;
  logic [11:0]          xpos_player2;
  logic [11:0]          ypos_player2;
  logic                 vblnk;
  state_pkg::g_state    game_state;
  logic                 level_init;
  modport master (
    output mouse_left, mouse_right, xpos_mouse, ypos_mouse,
    output xpos_player1, ypos_player1, xpos_player2, ypos_player2, vblnk,
    input  game_state, level_init
  );
  modport slave (
    input  mouse_left, mouse_right, xpos_mouse, ypos_mouse,
    input  xpos_player1, ypos_player1, xpos_player2, ypos_player2, vblnk,
    output game_state, level_init
  );
endinterface

// File: rtl/game_state_ctl.sv
// game_state_ctl: START/LEVEL_1/FINISH sequencer that switches screens only on vblnk rising edges
// Ports: clk_40 pixel clock, rst sync active-high reset, io (game_state_ctl_if.slave):
//   mouse_left/mouse_right buttons, xpos/ypos of mouse and both players, vblnk frame blank,
//   game_state current screen, level_init one-cycle pulse when LEVEL_1 is entered.
// Optional: define GAME_ESC_EN to let a mouse_right click in LEVEL_1 abort back to START.
module game_state_ctl
  import state_pkg::*;
#(
  parameter int unsigned START_BTN_X     = 352,
  parameter int unsigned START_BTN_Y     = 280,
  parameter int unsigned START_BTN_W     = 96,
  parameter int unsigned START_BTN_H     = 40,
  parameter int unsigned EXIT_X          = 700,
  parameter int unsigned EXIT_Y          = 500,
  parameter int unsigned EXIT_W          = 100,
  parameter int unsigned EXIT_H          = 100,
  parameter int unsigned WIN_HOLD_FRAMES = 30,
  parameter int unsigned FINISH_FRAMES   = 300
) (
  input  logic             clk_40,
  input  logic             rst,
  game_state_ctl_if.slave  io
);
  localparam int WW = $clog2(WIN_HOLD_FRAMES + 1);
  localparam int FW = $clog2(FINISH_FRAMES + 1);
  localparam logic [WW-1:0] WIN_MAX = WW'(WIN_HOLD_FRAMES);
  localparam logic [FW-1:0] FIN_MAX = FW'(FINISH_FRAMES);
  function automatic logic in_box(input logic [11:0] x, input logic [11:0] y,
                                  input int unsigned bx, input int unsigned by,
                                  input int unsigned bw, input int unsigned bh);
    logic [12:0] xe, ye;
    xe = {1'b0, x};
    ye = {1'b0, y};
    return (xe >= 13'(bx)) && (xe < 13'(bx + bw)) && (ye >= 13'(by)) && (ye < 13'(by + bh));
  endfunction
  g_state        state_q, state_d, target;
  logic          pending_q, pending_d;
  logic          level_init_q, level_init_d;
  logic          mouse_left_q, vblnk_q;
  logic [WW-1:0] win_cnt_q, win_cnt_d, win_nxt;
  logic [FW-1:0] fin_cnt_q, fin_cnt_d, fin_nxt;
  logic          click, frame_edge, in_start, both_in, abort, evt, req_next;
  assign click      = io.mouse_left & ~mouse_left_q;
  assign frame_edge = io.vblnk & ~vblnk_q;
  assign in_start   = in_box(io.xpos_mouse, io.ypos_mouse, START_BTN_X, START_BTN_Y, START_BTN_W, START_BTN_H);
  assign both_in    = in_box(io.xpos_player1, io.ypos_player1, EXIT_X, EXIT_Y, EXIT_W, EXIT_H) &
                      in_box(io.xpos_player2, io.ypos_player2, EXIT_X, EXIT_Y, EXIT_W, EXIT_H);
  assign win_nxt    = both_in ? ((win_cnt_q == WIN_MAX) ? WIN_MAX : win_cnt_q + 1'b1) : '0;
  assign fin_nxt    = (fin_cnt_q == FIN_MAX) ? FIN_MAX : fin_cnt_q + 1'b1;
`ifdef GAME_ESC_EN
  logic mouse_right_q;
  always_ff @(posedge clk_40) mouse_right_q <= rst ? 1'b0 : io.mouse_right;
  assign abort = io.mouse_right & ~mouse_right_q;
`else
  logic unused_mouse_right;
  assign unused_mouse_right = io.mouse_right;
  assign abort = 1'b0;
`endif
  always_comb begin
    state_d      = state_q;
    win_cnt_d    = win_cnt_q;
    fin_cnt_d    = fin_cnt_q;
    level_init_d = 1'b0;
    evt          = 1'b0;
    target       = START;
    case (state_q)
      START: begin
        evt    = click & in_start;
        target = LEVEL_1;
      end
      LEVEL_1: begin
        win_cnt_d = frame_edge ? win_nxt : win_cnt_q;
        evt       = (frame_edge & (win_nxt == WIN_MAX)) | abort;
        // win events only arise on a frame edge, so a held request here can only be an abort
        target    = (abort | pending_q) ? START : FINISH;
      end
      FINISH: begin
        fin_cnt_d = frame_edge ? fin_nxt : fin_cnt_q;
        evt       = click | (frame_edge & (fin_nxt == FIN_MAX));
        target    = START;
      end
      default: state_d = START;
    endcase
    req_next  = pending_q | evt;
    pending_d = req_next & ~frame_edge;
    if (frame_edge & req_next) begin
      state_d      = target;
      win_cnt_d    = '0;
      fin_cnt_d    = '0;
      level_init_d = (target == LEVEL_1);
    end
  end
  always_ff @(posedge clk_40) begin
    if (rst) begin
      state_q      <= START;
      pending_q    <= 1'b0;
      level_init_q <= 1'b0;
      win_cnt_q    <= '0;
      fin_cnt_q    <= '0;
      mouse_left_q <= 1'b0;
      vblnk_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      level_init_q <= level_init_d;
      win_cnt_q    <= win_cnt_d;
      fin_cnt_q    <= fin_cnt_d;
      mouse_left_q <= io.mouse_left;
      vblnk_q      <= io.vblnk;
    end
  end
  assign io.game_state = state_q;
  assign io.level_init = level_init_q;
endmodule

// File: tb/tb_game_state_ctl.sv
// tb_game_state_ctl: random and directed stimulus against a frame-level reference model of the sequencer
module tb_game_state_ctl;
  localparam int S_START = 0;
  localparam int S_LEVEL = 1;
  localparam int S_FIN   = 2;
  logic clk_40 = 1'b0;
  logic rst    = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  bit   cmp_en = 1'b0;
  game_state_ctl_if bus ();
  game_state_ctl dut (.clk_40(clk_40), .rst(rst), .io(bus));
  always #5 clk_40 = ~clk_40;
  int m_state, m_win, m_fin, m_ptgt;
  bit m_init, pl, pv, c_click, c_fe, c_both;
`ifdef GAME_ESC_EN
  bit pr, c_rc;
`endif
  function automatic bit inside_box(input int x, input int y, input int bx, input int by, input int bw, input int bh);
    return x >= bx && x < bx + bw && y >= by && y < by + bh;
  endfunction
  // a START request (abort) outranks any other request raised in the same frame
  task automatic want(input int t);
    if (m_ptgt < 0 || t == S_START) m_ptgt = t;
  endtask
  always @(posedge clk_40) begin
    if (rst) begin
      m_state = S_START; m_win = 0; m_fin = 0; m_ptgt = -1; m_init = 0; pl = 0; pv = 0;
`ifdef GAME_ESC_EN
      pr = 0;
`endif
    end else begin
      c_click = bus.mouse_left && !pl;
      c_fe    = bus.vblnk && !pv;
      c_both  = inside_box(int'(bus.xpos_player1), int'(bus.ypos_player1), 700, 500, 100, 100) &&
                inside_box(int'(bus.xpos_player2), int'(bus.ypos_player2), 700, 500, 100, 100);
      m_init  = 0;
      if (m_state == S_START && c_click && inside_box(int'(bus.xpos_mouse), int'(bus.ypos_mouse), 352, 280, 96, 40))
        want(S_LEVEL);
      if (m_state == S_LEVEL) begin
        if (c_fe) m_win = c_both ? (m_win < 30 ? m_win + 1 : 30) : 0;
        if (c_fe && m_win == 30) want(S_FIN);
`ifdef GAME_ESC_EN
        c_rc = bus.mouse_right && !pr;
        if (c_rc) want(S_START);
`endif
      end
      if (m_state == S_FIN) begin
        if (c_fe && m_fin < 300) m_fin++;
        if (c_click || (c_fe && m_fin == 300)) want(S_START);
      end
      if (c_fe && m_ptgt >= 0) begin
        m_init = (m_ptgt == S_LEVEL);
        m_state = m_ptgt; m_ptgt = -1; m_win = 0; m_fin = 0;
      end
      pl = bus.mouse_left; pv = bus.vblnk;
`ifdef GAME_ESC_EN
      pr = bus.mouse_right;
`endif
    end
  end
  always @(negedge clk_40) begin
    if (cmp_en) begin
      vectors++;
      if (bus.game_state !== 2'(m_state) || bus.level_init !== m_init) begin
        miscompares++;
        $display("FAIL model_cmp t=%0t game_state=%0d expected=%0d level_init=%0b expected=%0b",
                 $time, bus.game_state, m_state, bus.level_init, m_init);
      end
    end
  end
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_40);
  endtask
  task automatic frame(input int low);
    bus.vblnk = 1'b0;
    cyc(low);
    bus.vblnk = 1'b1;
    cyc(1);
  endtask
  task automatic click_at(input int x, input int y);
    bus.xpos_mouse = 12'(x); bus.ypos_mouse = 12'(y);
    bus.mouse_left = 1'b1;
    cyc(1);
    bus.mouse_left = 1'b0;
    cyc(1);
  endtask
  task automatic players(input int x1, input int y1, input int x2, input int y2);
    bus.xpos_player1 = 12'(x1); bus.ypos_player1 = 12'(y1);
    bus.xpos_player2 = 12'(x2); bus.ypos_player2 = 12'(y2);
  endtask
  task automatic do_reset;
    bus.vblnk = 1'b0; bus.mouse_left = 1'b0; bus.mouse_right = 1'b0;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask
  task automatic to_level;
    do_reset;
    players(0, 0, 0, 0);
    click_at(400, 300);
    frame(4);
  endtask
  task automatic to_finish;
    to_level;
    players(720, 520, 720, 520);
    repeat (30) frame(4);
  endtask
  initial begin
    bus.mouse_left = 0; bus.mouse_right = 0; bus.vblnk = 0;
    bus.xpos_mouse = 0; bus.ypos_mouse = 0;
    players(0, 0, 0, 0);
    cyc(3);
    rst = 1'b0;
    cmp_en = 1'b1;
    do_reset;
    chk("reset_state", int'(bus.game_state), S_START);
    chk("reset_init", int'(bus.level_init), 0);
    click_at(400, 300);
    bus.vblnk = 1'b0;
    cyc(98);
    chk("start_before_edge", int'(bus.game_state), S_START);
    bus.vblnk = 1'b1;
    cyc(1);
    chk("start_to_level", int'(bus.game_state), S_LEVEL);
    chk("level_init_pulse", int'(bus.level_init), 1);
    cyc(1);
    chk("level_init_single", int'(bus.level_init), 0);
    do_reset;
    click_at(351, 300);
    repeat (3) frame(4);
    chk("click_left_outside", int'(bus.game_state), S_START);
    click_at(448, 300);
    repeat (3) frame(4);
    chk("click_right_outside", int'(bus.game_state), S_START);
    click_at(352, 280);
    frame(4);
    chk("click_corner_inside", int'(bus.game_state), S_LEVEL);
    players(720, 520, 720, 520);
    repeat (29) frame(4);
    chk("win_29_frames", int'(bus.game_state), S_LEVEL);
    frame(4);
    chk("win_30_frames", int'(bus.game_state), S_FIN);
    to_level;
    players(720, 520, 720, 520);
    repeat (29) frame(4);
    players(720, 520, 600, 520);
    frame(4);
    players(720, 520, 720, 520);
    repeat (29) frame(4);
    chk("win_restart_29", int'(bus.game_state), S_LEVEL);
    frame(4);
    chk("win_restart_30", int'(bus.game_state), S_FIN);
    players(720, 520, 0, 0);
    repeat (299) frame(4);
    chk("finish_299", int'(bus.game_state), S_FIN);
    frame(4);
    chk("finish_timeout", int'(bus.game_state), S_START);
    to_finish;
    repeat (9) frame(4);
    bus.vblnk = 1'b0;
    click_at(10, 10);
    cyc(2);
    chk("finish_click_held", int'(bus.game_state), S_FIN);
    bus.vblnk = 1'b1;
    cyc(1);
    chk("finish_click", int'(bus.game_state), S_START);
    to_level;
    players(720, 520, 720, 520);
    repeat (29) frame(4);
    bus.vblnk = 1'b0;
    cyc(2);
    bus.mouse_right = 1'b1;
    cyc(1);
    bus.mouse_right = 1'b0;
    cyc(2);
    bus.vblnk = 1'b1;
    cyc(1);
`ifdef GAME_ESC_EN
    chk("esc_vs_win", int'(bus.game_state), S_START);
`else
    chk("esc_vs_win", int'(bus.game_state), S_FIN);
`endif
    do_reset;
    click_at(400, 300);
    cyc(3);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    chk("rst_pending_state", int'(bus.game_state), S_START);
    frame(4);
    chk("rst_pending_dropped", int'(bus.game_state), S_START);
    chk("rst_no_init", int'(bus.level_init), 0);
    do_reset;
    for (int f = 0; f < 700; f++) begin
      if ($urandom_range(99) < 97) players($urandom_range(700, 799), $urandom_range(500, 599), $urandom_range(700, 799), $urandom_range(500, 599));
      else players($urandom_range(600, 820), $urandom_range(480, 620), $urandom_range(600, 820), $urandom_range(480, 620));
      bus.vblnk = 1'b0;
      for (int c = 0; c < int'($urandom_range(4, 12)); c++) begin
        if ($urandom_range(1)) begin
          bus.xpos_mouse = 12'($urandom_range(340, 460)); bus.ypos_mouse = 12'($urandom_range(270, 330));
        end else begin
          bus.xpos_mouse = 12'($urandom_range(4095)); bus.ypos_mouse = 12'($urandom_range(4095));
        end
        bus.mouse_left  = ($urandom_range(5) == 0);
        bus.mouse_right = ($urandom_range(40) == 0);
        rst = ($urandom_range(500) == 0);
        cyc(1);
      end
      rst = 1'b0;
      bus.vblnk = 1'b1;
      cyc(1 + int'($urandom_range(2)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
